// File: rtl/pipeline_ctrl.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, branch squash,
// EX operand forwarding selects and saturating stall/flush event counters.
module pipeline_ctrl #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [8:0]       id_ctrl,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_taken,
  output logic             ex_regdst,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             ex_branch,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [RA_W-1:0]  wb_wreg,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Control word layout: {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}
  logic [8:0]      ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic            mem_memtoreg_q, mem_regwrite_q, mem_memread_q, mem_memwrite_q;
  logic [RA_W-1:0] mem_wreg_q;
  logic            wb_memtoreg_q, wb_regwrite_q;
  logic [RA_W-1:0] wb_wreg_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic            uses_rt, load_use, ex_memread;
  logic [RA_W-1:0] ex_wreg;

  assign ex_memread = ex_ctrl_q[4];
  assign ex_wreg    = ex_ctrl_q[8] ? ex_rd_q : ex_rt_q;
  assign uses_rt    = id_ctrl[8] | id_ctrl[3] | id_ctrl[2];

  always_comb begin
    load_use   = ex_memread & (ex_rt_q != '0) & id_valid &
                 ((ex_rt_q == id_rs) | (uses_rt & (ex_rt_q == id_rt)));
    flush_ifid = ex_ctrl_q[2] & ex_taken;
    // A taken branch squashes ID anyway, so holding it would be pointless.
    stall      = load_use & ~flush_ifid;
    ex_ctrl_d  = (id_valid & ~stall & ~flush_ifid) ? id_ctrl : 9'd0;
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite_q && mem_wreg_q != '0 && mem_wreg_q == ex_rs_q) begin
      fwd_a = 2'b10;
    end else if (wb_regwrite_q && wb_wreg_q != '0 && wb_wreg_q == ex_rs_q) begin
      fwd_a = 2'b01;
    end
    if (mem_regwrite_q && mem_wreg_q != '0 && mem_wreg_q == ex_rt_q) begin
      fwd_b = 2'b10;
    end else if (wb_regwrite_q && wb_wreg_q != '0 && wb_wreg_q == ex_rt_q) begin
      fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q      <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_wreg_q     <= '0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_wreg_q      <= '0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rs_q        <= id_rs;
      ex_rt_q        <= id_rt;
      ex_rd_q        <= id_rd;
      mem_memtoreg_q <= ex_ctrl_q[6];
      mem_regwrite_q <= ex_ctrl_q[5];
      mem_memread_q  <= ex_ctrl_q[4];
      mem_memwrite_q <= ex_ctrl_q[3];
      mem_wreg_q     <= ex_wreg;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_wreg_q      <= mem_wreg_q;
      if (stall && stall_cnt_q != CntMax) stall_cnt_q <= stall_cnt_q + CntOne;
      if (flush_ifid && flush_cnt_q != CntMax) flush_cnt_q <= flush_cnt_q + CntOne;
    end
  end

  assign ex_regdst    = ex_ctrl_q[8];
  assign ex_alusrc    = ex_ctrl_q[7];
  assign ex_branch    = ex_ctrl_q[2];
  assign ex_aluop     = ex_ctrl_q[1:0];
  assign mem_memread  = mem_memread_q;
  assign mem_memwrite = mem_memwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_wreg      = wb_wreg_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance with 2-bit counters covers saturation.
module tb_pipeline_ctrl;

  localparam int unsigned RA_W = 5;
  localparam logic [8:0] LW   = 9'b011110000;
  localparam logic [8:0] ADD  = 9'b100100010;
  localparam logic [8:0] ADDI = 9'b010100000;
  localparam logic [8:0] SW   = 9'b010001000;
  localparam logic [8:0] BEQ  = 9'b000000101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [8:0] id_ctrl = '0;
  logic [RA_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic ex_taken = 1'b0;

  logic ex_regdst, ex_alusrc, ex_branch, mem_memread, mem_memwrite;
  logic wb_memtoreg, wb_regwrite, stall, flush_ifid;
  logic [1:0] ex_aluop, fwd_a, fwd_b;
  logic [RA_W-1:0] wb_wreg;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_ex_regdst, s_ex_alusrc, s_ex_branch, s_mem_memread, s_mem_memwrite;
  logic s_wb_memtoreg, s_wb_regwrite, s_stall, s_flush_ifid;
  logic [1:0] s_ex_aluop, s_fwd_a, s_fwd_b;
  logic [RA_W-1:0] s_wb_wreg;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.RA_W(RA_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_taken(ex_taken),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_branch(ex_branch), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush_ifid(flush_ifid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.RA_W(RA_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_taken(ex_taken),
    .ex_regdst(s_ex_regdst), .ex_alusrc(s_ex_alusrc), .ex_aluop(s_ex_aluop),
    .ex_branch(s_ex_branch), .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite),
    .wb_memtoreg(s_wb_memtoreg), .wb_regwrite(s_wb_regwrite), .wb_wreg(s_wb_wreg),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall), .flush_ifid(s_flush_ifid),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [8:0] c, input logic [RA_W-1:0] rs,
                        input logic [RA_W-1:0] rt, input logic [RA_W-1:0] rd);
    id_valid = v;
    id_ctrl  = c;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    ex_taken = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [21:0] all_out;
    do_reset();
    set_id(1'b1, LW, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++;
    if (mem_memread !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_memread got %b want 1", mem_memread);
    end
    #3;
    rst_n = 1'b0;
    #1;
    all_out = {ex_regdst, ex_alusrc, ex_aluop, ex_branch, mem_memread, mem_memwrite,
               wb_memtoreg, wb_regwrite, wb_wreg, fwd_a, fwd_b, stall, flush_ifid};
    checks++;
    if (all_out !== 22'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset outputs got %h cnt %h/%h want 0", all_out, stall_cnt, flush_cnt);
    end
    #1;
    rst_n = 1'b1;
    set_id(1'b1, LW, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({ex_alusrc, mem_memread} !== 2'b10) begin
      errors++;
      $display("FAIL lw_edge1 alusrc,memread got %b want 10", {ex_alusrc, mem_memread});
    end
    tick();
    checks++;
    if ({mem_memread, wb_regwrite} !== 2'b10) begin
      errors++;
      $display("FAIL lw_edge2 memread,wb_regwrite got %b want 10", {mem_memread, wb_regwrite});
    end
    tick();
    checks++;
    if ({wb_memtoreg, wb_regwrite, wb_wreg} !== {2'b11, 5'd5}) begin
      errors++;
      $display("FAIL lw_edge3 wb got %b want 1100101", {wb_memtoreg, wb_regwrite, wb_wreg});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, LW, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(1'b1, ADD, 5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got %b want 1", stall);
    end
    tick();
    checks++;
    if ({stall, ex_regdst, ex_alusrc, ex_aluop, ex_branch, mem_memread} !== 7'b0000001) begin
      errors++;
      $display("FAIL load_use_bubble got %b want 0000001",
               {stall, ex_regdst, ex_alusrc, ex_aluop, ex_branch, mem_memread});
    end
    tick();
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({ex_regdst, ex_aluop, fwd_a, fwd_b, stall_cnt} !== {1'b1, 2'b10, 2'b01, 2'b00, 16'd1}) begin
      errors++;
      $display("FAIL load_use_fwd regdst %b aluop %b fwd_a %b fwd_b %b cnt %0d want 1 10 01 00 1",
               ex_regdst, ex_aluop, fwd_a, fwd_b, stall_cnt);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    set_id(1'b1, LW, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, ADD, 5'd0, 5'd2, 5'd3);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL no_stall_r0 got %b want 0", stall);
    end
    set_id(1'b1, LW, 5'd1, 5'd7, 5'd0);
    tick();
    set_id(1'b1, ADDI, 5'd3, 5'd7, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL no_stall_addi got %b want 0", stall);
    end
    set_id(1'b1, SW, 5'd3, 5'd7, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_sw_rt got %b want 1", stall);
    end
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, ADD, 5'd1, 5'd2, 5'd4);
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_none got %b want 0000", {fwd_a, fwd_b});
    end
    tick();
    set_id(1'b1, ADD, 5'd4, 5'd4, 5'd8);
    tick();
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      errors++;
      $display("FAIL fwd_priority got %b want 1010", {fwd_a, fwd_b});
    end
    do_reset();
    set_id(1'b1, ADD, 5'd1, 5'd2, 5'd4);
    tick();
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, ADD, 5'd4, 5'd4, 5'd8);
    tick();
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      errors++;
      $display("FAIL fwd_memwb got %b want 0101", {fwd_a, fwd_b});
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1'b1, BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    ex_taken = 1'b1;
    set_id(1'b1, ADD, 5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if ({flush_ifid, stall} !== 2'b10) begin
      errors++;
      $display("FAIL branch_taken flush,stall got %b want 10", {flush_ifid, stall});
    end
    tick();
    ex_taken = 1'b0;
    checks++;
    if ({ex_regdst, ex_alusrc, ex_aluop, ex_branch, flush_cnt} !== {5'b0, 16'd1}) begin
      errors++;
      $display("FAIL branch_bubble ex %b flush_cnt %0d want 00000 1",
               {ex_regdst, ex_alusrc, ex_aluop, ex_branch}, flush_cnt);
    end
    set_id(1'b1, BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, ADD, 5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if (flush_ifid !== 1'b0) begin
      errors++;
      $display("FAIL branch_not_taken flush got %b want 0", flush_ifid);
    end
    tick();
    checks++;
    if ({ex_regdst, flush_cnt} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL branch_not_taken_pass regdst %b flush_cnt %0d want 1 1", ex_regdst, flush_cnt);
    end
    // Synthetic word with both memRead and branch set exercises flush-over-stall priority.
    do_reset();
    set_id(1'b1, 9'b000010100, 5'd1, 5'd5, 5'd0);
    tick();
    ex_taken = 1'b1;
    set_id(1'b1, ADD, 5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if ({flush_ifid, stall} !== 2'b10) begin
      errors++;
      $display("FAIL flush_over_stall got %b want 10", {flush_ifid, stall});
    end
    ex_taken = 1'b0;
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_saturation();
    do_reset();
    set_id(1'b1, LW, 5'd5, 5'd5, 5'd0);
    repeat (6) tick();
    checks++;
    if ({s_stall_cnt, stall_cnt} !== {2'd3, 16'd3}) begin
      errors++;
      $display("FAIL sat_reach narrow %0d wide %0d want 3 3", s_stall_cnt, stall_cnt);
    end
    repeat (4) tick();
    checks++;
    if ({s_stall_cnt, stall_cnt} !== {2'd3, 16'd5}) begin
      errors++;
      $display("FAIL sat_hold narrow %0d wide %0d want 3 5", s_stall_cnt, stall_cnt);
    end
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_forward();
    test_branch();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
